// File: rtl/xilinx_phy10g_rx_reset_seq.sv
// ---------------------------------------------------------------------------
// xilinx_phy10g_rx_reset_seq
//
// Per-lane RX bring-up sequencer for the 10G Ethernet PHY. The sequence is:
//   1. Wait for the shared configuration hold-off and for QPLL lock.
//   2. Pulse GTRXRESET.
//   3. Wait for RXRESETDONE.
//   4. Raise RXUSERRDY.
//   5. Qualify PCS block lock, then declare the lane ready.
// Reset-done and lock timeouts re-run the reset pulse and bump a saturating
// retry counter. Loss of QPLL lock at any point past WAIT_QPLL drops back to
// WAIT_QPLL without counting a retry.
//
// Optional feature macro: PHY10G_RX_LOCK_WATCHDOG_EN
//   Defined   : LOSS_FILTER consecutive cycles without block lock while LOCKED
//               trigger a retry.
//   Undefined : LOCKED is left only on QPLL loss or reset.
//
// Ports
//   clk156               in   sequencer clock (156.25 MHz)
//   gttxreset_txusrclk2  in   async active-high reset; deassertion is
//                             synchronous to clk156
//   reset_counter_done_i in   shared configuration hold-off elapsed
//                             (clk156 domain)
//   qplllock_i           in   QPLL lock (async, synchronised here)
//   rxresetdone_i        in   GT RXRESETDONE (async, synchronised here)
//   block_lock_i         in   PCS block lock (async, synchronised here)
//   gtrxreset_o          out  GT RX reset
//   rxuserrdy_o          out  GT RXUSERRDY
//   rx_ready_o           out  lane RX usable
//   retry_count_o        out  saturating retry counter
//   state_o              out  current FSM state encoding (debug/status)
// ---------------------------------------------------------------------------
module xilinx_phy10g_rx_reset_seq #(
    parameter int unsigned RESET_PULSE_CYCLES = 4,
    parameter logic [15:0] DONE_TIMEOUT       = 16'd2048,
    parameter logic [15:0] LOCK_TIMEOUT       = 16'd50000,
    parameter logic [7:0]  LOSS_FILTER        = 8'd16
) (
    input  logic       clk156,
    input  logic       gttxreset_txusrclk2,
    input  logic       reset_counter_done_i,
    input  logic       qplllock_i,
    input  logic       rxresetdone_i,
    input  logic       block_lock_i,
    output logic       gtrxreset_o,
    output logic       rxuserrdy_o,
    output logic       rx_ready_o,
    output logic [7:0] retry_count_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_WAIT_QPLL      = 3'd1,
        ST_ASSERT_RESET   = 3'd2,
        ST_WAIT_RESETDONE = 3'd3,
        ST_USERRDY        = 3'd4,
        ST_WAIT_LOCK      = 3'd5,
        ST_LOCKED         = 3'd6
    } state_t;

    localparam logic [15:0] PULSE_LAST = 16'(RESET_PULSE_CYCLES - 1);
    localparam logic [15:0] DONE_LAST  = DONE_TIMEOUT - 16'd1;
    localparam logic [15:0] LOCK_LAST  = LOCK_TIMEOUT - 16'd1;

    // ------------------------------------------------------------------
    // Two-flop synchronisers.
    // Bit order is {block_lock, rxresetdone, qplllock}.
    // ------------------------------------------------------------------
    logic [2:0] sync_meta_q, sync_meta_d;
    logic [2:0] sync_q, sync_d;
    logic       qplllock_s;
    logic       rxresetdone_s;
    logic       block_lock_s;

    always_comb begin
        sync_meta_d = {block_lock_i, rxresetdone_i, qplllock_i};
        sync_d      = sync_meta_q;
    end

    always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
        if (gttxreset_txusrclk2) begin
            sync_meta_q <= 3'b000;
            sync_q      <= 3'b000;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
        end
    end

    assign qplllock_s    = sync_q[0];
    assign rxresetdone_s = sync_q[1];
    assign block_lock_s  = sync_q[2];

    // ------------------------------------------------------------------
    // FSM state, timer, retry counter and registered outputs
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  retry_count_q, retry_count_d;
    logic        gtrxreset_q, gtrxreset_d;
    logic        rxuserrdy_q, rxuserrdy_d;
    logic        rx_ready_q, rx_ready_d;
    logic        retry;
    logic        lock_lost;

    always_comb begin
        state_d = state_q;
        retry   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reset_counter_done_i) state_d = ST_WAIT_QPLL;
            end
            ST_WAIT_QPLL: begin
                if (qplllock_s) state_d = ST_ASSERT_RESET;
            end
            ST_ASSERT_RESET: begin
                if (timer_q == PULSE_LAST) state_d = ST_WAIT_RESETDONE;
            end
            ST_WAIT_RESETDONE: begin
                // Success is tested before the timeout so it wins a tie.
                if (rxresetdone_s)           state_d = ST_USERRDY;
                else if (timer_q == DONE_LAST) retry = 1'b1;
            end
            ST_USERRDY: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (block_lock_s)              state_d = ST_LOCKED;
                else if (timer_q == LOCK_LAST) retry = 1'b1;
            end
            ST_LOCKED: begin
                if (lock_lost) retry = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retry) state_d = ST_ASSERT_RESET;

        // QPLL loss overrides every other transition and is not a retry.
        if ((state_q inside {ST_ASSERT_RESET, ST_WAIT_RESETDONE, ST_USERRDY,
                             ST_WAIT_LOCK, ST_LOCKED}) && !qplllock_s) begin
            state_d = ST_WAIT_QPLL;
            retry   = 1'b0;
        end

        retry_count_d = retry_count_q;
        if (retry && (retry_count_q != 8'hFF)) retry_count_d = retry_count_q + 8'd1;

        // Timer restarts on any state entry. It saturates rather than wraps
        // so that long stays in IDLE, WAIT_QPLL or LOCKED stay well defined.
        if (state_d != state_q)   timer_d = 16'd0;
        else if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
        else                      timer_d = timer_q;

        // Outputs are decoded from the next state so that they change on
        // the same edge that enters the state.
        gtrxreset_d = state_d inside {ST_IDLE, ST_WAIT_QPLL, ST_ASSERT_RESET};
        rxuserrdy_d = state_d inside {ST_USERRDY, ST_WAIT_LOCK, ST_LOCKED};
        rx_ready_d  = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
        if (gttxreset_txusrclk2) begin
            state_q       <= ST_IDLE;
            timer_q       <= 16'd0;
            retry_count_q <= 8'd0;
            gtrxreset_q   <= 1'b1;
            rxuserrdy_q   <= 1'b0;
            rx_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_count_q <= retry_count_d;
            gtrxreset_q   <= gtrxreset_d;
            rxuserrdy_q   <= rxuserrdy_d;
            rx_ready_q    <= rx_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional block-lock watchdog for the LOCKED state
    // ------------------------------------------------------------------
`ifdef PHY10G_RX_LOCK_WATCHDOG_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // The retry fires on the LOSS_FILTER-th consecutive low sample.
    always_comb begin
        lock_lost = !block_lock_s && (loss_cnt_q == LOSS_FILTER - 8'd1);
    end

    // The counter runs only while LOCKED is held. Entering LOCKED, leaving
    // it, or seeing block lock again all clear it.
    always_comb begin
        loss_cnt_d = 8'd0;
        if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED) && !block_lock_s)
            loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
        if (gttxreset_txusrclk2) loss_cnt_q <= 8'd0;
        else                     loss_cnt_q <= loss_cnt_d;
    end
`else
    // Without the watchdog, LOCKED is sticky until QPLL loss or reset.
    logic unused_loss_filter;

    always_comb begin
        lock_lost = 1'b0;
    end

    assign unused_loss_filter = ^LOSS_FILTER;
`endif

    assign gtrxreset_o   = gtrxreset_q;
    assign rxuserrdy_o   = rxuserrdy_q;
    assign rx_ready_o    = rx_ready_q;
    assign retry_count_o = retry_count_q;
    assign state_o       = state_q;

endmodule
